// File: rtl/execute_pipe_stage.sv
// Registered WISC execute stage: ALU, branch resolution, valid/ready handshake on both sides.
// Define EX_ITER_MUL_EN to build the iterative shift-add multiplier for op 7.
module execute_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc_inc,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_b_src,
  input  logic [PC_W-1:0]   in_disp,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_br,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [PC_W-1:0]   out_next_pc,
  output logic              out_redirect,
  output logic              out_err
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state_q, state_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [PC_W-1:0]   out_next_pc_q, out_next_pc_d;
  logic              out_redirect_q, out_redirect_d;
  logic              out_err_q, out_err_d;

  logic              out_free, accept, start_mul, alu_err;
  logic [DATA_W-1:0] b_eff, alu_res;
  logic [SH_W-1:0]   shamt;

`ifdef EX_ITER_MUL_EN
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d, mul_sum;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]   mul_pc_q, mul_pc_d, mul_disp_q, mul_disp_d;
  logic [1:0]        mul_br_q, mul_br_d;
  assign start_mul = accept & (in_op == 3'd7);
  assign mul_sum   = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
`else
  assign start_mul = 1'b0;
`endif

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == IDLE) && out_free && !flush;
  assign accept   = in_valid && in_ready;

  assign b_eff = in_b_src ? in_imm : in_b;
  assign shamt = b_eff[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (in_op)
      3'd0:    alu_res = in_a + b_eff;
      3'd1:    alu_res = in_a - b_eff;
      3'd2:    alu_res = in_a & b_eff;
      3'd3:    alu_res = in_a ^ b_eff;
      3'd4:    alu_res = in_a << shamt;
      3'd5:    alu_res = in_a >> shamt;
      3'd6:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(b_eff))};
      default: begin
`ifndef EX_ITER_MUL_EN
        alu_err = 1'b1;
`endif
      end
    endcase
  end

  // Returns {redirect, next_pc}; jump targets take the low PC_W bits of the result.
  function automatic logic [PC_W:0] resolve(input logic [DATA_W-1:0] res,
                                            input logic [PC_W-1:0]   pc_inc,
                                            input logic [PC_W-1:0]   disp,
                                            input logic [1:0]        br);
    logic [PC_W-1:0] target;
    target = pc_inc + disp;
    case (br)
      2'd1:    resolve = (res == '0) ? {1'b1, target} : {1'b0, pc_inc};
      2'd2:    resolve = (res != '0) ? {1'b1, target} : {1'b0, pc_inc};
      2'd3:    resolve = {1'b1, PC_W'(res)};
      default: resolve = {1'b0, pc_inc};
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_next_pc_d  = out_next_pc_q;
    out_redirect_d = out_redirect_q;
    out_err_d      = out_err_q;
`ifdef EX_ITER_MUL_EN
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_acc_d  = mul_acc_q;
    cnt_d      = cnt_q;
    mul_pc_d   = mul_pc_q;
    mul_disp_d = mul_disp_q;
    mul_br_d   = mul_br_q;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (flush) begin
      out_valid_d    = 1'b0;
      out_redirect_d = 1'b0;
      state_d        = IDLE;
`ifdef EX_ITER_MUL_EN
      cnt_d          = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && !start_mul) begin
            out_valid_d                     = 1'b1;
            out_result_d                    = alu_res;
            {out_redirect_d, out_next_pc_d} = resolve(alu_res, in_pc_inc, in_disp, in_br);
            out_err_d                       = alu_err;
          end
`ifdef EX_ITER_MUL_EN
          if (start_mul) begin
            mul_a_d    = in_a;
            mul_b_d    = b_eff;
            mul_acc_d  = '0;
            cnt_d      = '0;
            mul_pc_d   = in_pc_inc;
            mul_disp_d = in_disp;
            mul_br_d   = in_br;
            state_d    = MUL_BUSY;
          end
`endif
        end
`ifdef EX_ITER_MUL_EN
        MUL_BUSY: begin
          if (cnt_q != CNT_LAST) begin
            mul_acc_d = mul_sum;
            mul_a_d   = mul_a_q << 1;
            mul_b_d   = mul_b_q >> 1;
            cnt_d     = cnt_q + 1'b1;
          end else if (out_free) begin
            // Final bit folds straight into the output; holding here is idempotent.
            out_valid_d                     = 1'b1;
            out_result_d                    = mul_sum;
            {out_redirect_d, out_next_pc_d} = resolve(mul_sum, mul_pc_q, mul_disp_q, mul_br_q);
            out_err_d                       = 1'b0;
            cnt_d                           = '0;
            state_d                         = IDLE;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_next_pc_q  <= '0;
      out_redirect_q <= 1'b0;
      out_err_q      <= 1'b0;
`ifdef EX_ITER_MUL_EN
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_acc_q      <= '0;
      cnt_q          <= '0;
      mul_pc_q       <= '0;
      mul_disp_q     <= '0;
      mul_br_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_next_pc_q  <= out_next_pc_d;
      out_redirect_q <= out_redirect_d;
      out_err_q      <= out_err_d;
`ifdef EX_ITER_MUL_EN
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_acc_q      <= mul_acc_d;
      cnt_q          <= cnt_d;
      mul_pc_q       <= mul_pc_d;
      mul_disp_q     <= mul_disp_d;
      mul_br_q       <= mul_br_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_next_pc  = out_next_pc_q;
  assign out_redirect = out_redirect_q;
  assign out_err      = out_err_q;
endmodule

// File: tb/tb_execute_pipe_stage.sv
// Bench for execute_pipe_stage: vector table, hand sequences, randomized scoreboard run.
// MUL-specific sequences are compiled only when EX_ITER_MUL_EN is defined.
module tb_execute_pipe_stage;
  logic        clk, rst_n, flush, in_valid, in_ready, in_b_src;
  logic [15:0] in_pc_inc, in_a, in_b, in_imm, in_disp;
  logic [2:0]  in_op;
  logic [1:0]  in_br;
  logic        out_valid, out_ready, out_redirect, out_err;
  logic [15:0] out_result, out_next_pc;

  int n_vec = 0;
  int n_bad = 0;

  execute_pipe_stage #(.DATA_W(16), .PC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_inc(in_pc_inc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_b_src(in_b_src),
    .in_disp(in_disp), .in_op(in_op), .in_br(in_br), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_next_pc(out_next_pc),
    .out_redirect(out_redirect), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, imm;
    logic        bsrc;
    logic [15:0] pc, disp;
    logic [1:0]  br;
    logic [15:0] er, enpc;
    logic        erd, eerr;
  } vec_t;

  typedef struct packed {
    logic [15:0] r, npc;
    logic        rd, err;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] br, input logic [15:0] pc, input logic [15:0] disp);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_imm = 16'h0; in_b_src = 1'b0;
    in_br = br; in_pc_inc = pc; in_disp = disp;
  endtask

  // Reference computed directly from the ISA rules with integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] pc, input logic [15:0] disp, input logic [1:0] br);
    exp_t e;
    int unsigned ua, ub, r;
    ua = a; ub = b; r = 0;
    e.err = 1'b0;
    case (op)
      3'd0: r = (ua + ub) % 65536;
      3'd1: r = (ua + 65536 - ub) % 65536;
      3'd2: r = ua & ub;
      3'd3: r = ua ^ ub;
      3'd4: r = (ua << (ub % 16)) % 65536;
      3'd5: r = ua >> (ub % 16);
      3'd6: r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin
`ifdef EX_ITER_MUL_EN
        r = (ua * ub) % 65536;
`else
        r = 0;
        e.err = 1'b1;
`endif
      end
    endcase
    e.r = 16'(r);
    e.rd = (br == 2'd3) || (br == 2'd1 && r == 0) || (br == 2'd2 && r != 0);
    if (br == 2'd3) e.npc = 16'(r);
    else if (e.rd) e.npc = 16'((int'(pc) + int'(disp)) % 65536);
    else e.npc = pc;
    return e;
  endfunction

  vec_t vt[$];
  exp_t sq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc_inc = '0; in_a = '0; in_b = '0; in_imm = '0; in_b_src = 1'b0;
    in_disp = '0; in_op = '0; in_br = '0;

    //              op    a        b        imm      bs  pc       disp     br  er       enpc     rd eerr
    vt.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h0000, 0, 16'h0100, 16'h0020, 0, 16'h8000, 16'h0100, 0, 0});
    vt.push_back('{3'd1, 16'h0000, 16'h0001, 16'h0000, 0, 16'h0100, 16'h0020, 0, 16'hFFFF, 16'h0100, 0, 0});
    vt.push_back('{3'd1, 16'h0005, 16'h0005, 16'h0000, 0, 16'h0010, 16'hFFF0, 1, 16'h0000, 16'h0000, 1, 0});
    vt.push_back('{3'd1, 16'h0006, 16'h0005, 16'h0000, 0, 16'h0010, 16'hFFF0, 1, 16'h0001, 16'h0010, 0, 0});
    vt.push_back('{3'd6, 16'h8000, 16'h0001, 16'h0000, 0, 16'h0100, 16'h0020, 0, 16'h0001, 16'h0100, 0, 0});
    vt.push_back('{3'd6, 16'h0001, 16'h8000, 16'h0000, 0, 16'h0100, 16'h0020, 0, 16'h0000, 16'h0100, 0, 0});
    vt.push_back('{3'd5, 16'h8000, 16'hFFFF, 16'h000F, 1, 16'h0100, 16'h0020, 0, 16'h0001, 16'h0100, 0, 0});
    vt.push_back('{3'd2, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 16'h0100, 16'h0020, 0, 16'h3030, 16'h0100, 0, 0});
    vt.push_back('{3'd3, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 16'h0100, 16'h0020, 0, 16'hCCCC, 16'h0100, 0, 0});
    vt.push_back('{3'd4, 16'h0001, 16'h0014, 16'h0000, 0, 16'h0100, 16'h0020, 0, 16'h0010, 16'h0100, 0, 0});
    vt.push_back('{3'd0, 16'h0001, 16'h0001, 16'h0000, 0, 16'h0100, 16'h0020, 2, 16'h0002, 16'h0120, 1, 0});
    vt.push_back('{3'd0, 16'h0200, 16'h0034, 16'h0000, 0, 16'h0100, 16'h0020, 3, 16'h0234, 16'h0234, 1, 0});
`ifndef EX_ITER_MUL_EN
    vt.push_back('{3'd7, 16'h0003, 16'h0004, 16'h0000, 0, 16'h0100, 16'h0020, 2, 16'h0000, 16'h0100, 0, 1});
`endif

    #2;
    chk("reset_outs", {out_valid, out_result, out_next_pc, out_redirect, out_err}, '0);
    step(); step();
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ready_after_reset", in_ready, 1);
    step();

    foreach (vt[i]) begin
      in_valid = 1'b1; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b; in_imm = vt[i].imm;
      in_b_src = vt[i].bsrc; in_pc_inc = vt[i].pc; in_disp = vt[i].disp; in_br = vt[i].br;
      step();
      chk($sformatf("vec%0d", i), {out_valid, out_result, out_next_pc, out_redirect, out_err},
          {1'b1, vt[i].er, vt[i].enpc, vt[i].erd, vt[i].eerr});
    end
    in_valid = 1'b0;
    step();
    chk("valid_drops", out_valid, 0);

    // Backpressure: first result holds, second waits, then appears exactly once.
    out_ready = 1'b0;
    drive(3'd0, 16'd1, 16'd2, 2'd0, 16'h0100, 16'h0);
    step();
    chk("bp_first", {out_valid, out_result}, {1'b1, 16'd3});
    drive(3'd0, 16'd10, 16'd20, 2'd0, 16'h0100, 16'h0);
    #1;
    chk("bp_ready_low", in_ready, 0);
    step();
    chk("bp_hold", {out_valid, out_result}, {1'b1, 16'd3});
    out_ready = 1'b1;
    #1;
    chk("bp_ready_high", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_second", {out_valid, out_result}, {1'b1, 16'd30});
    step();
    chk("bp_no_dup", out_valid, 0);

    // Flush kills a held output and blocks acceptance in the same cycle.
    out_ready = 1'b0;
    drive(3'd0, 16'd0, 16'd5, 2'd3, 16'h0100, 16'h0);
    step();
    chk("fl_loaded", {out_valid, out_redirect}, 2'b11);
    flush = 1'b1; out_ready = 1'b1;
    drive(3'd0, 16'd7, 16'd7, 2'd0, 16'h0100, 16'h0);
    #1;
    chk("fl_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_cleared", {out_valid, out_redirect}, 2'b00);
    step();
    chk("fl_not_accepted", out_valid, 0);

    // Mid-cycle asynchronous reset.
    drive(3'd0, 16'd1, 16'd2, 2'd3, 16'h0100, 16'h0);
    step();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, out_result, out_next_pc, out_redirect, out_err}, '0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ready_after_rst2", in_ready, 1);
    step();

`ifdef EX_ITER_MUL_EN
    begin
      int vc;
      drive(3'd7, 16'h0123, 16'h0045, 2'd2, 16'h0040, 16'h0010);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("mul_busy%0d", k), {in_ready, out_valid}, 2'b00);
        step();
      end
      chk("mul_result", {out_valid, out_result, out_next_pc, out_redirect, out_err},
          {1'b1, 16'h4E6F, 16'h0050, 1'b1, 1'b0});
      step();

      drive(3'd7, 16'h0123, 16'h0045, 2'd0, 16'h0040, 16'h0010);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 7; k++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("mulfl_noout", out_valid, 0);
      drive(3'd0, 16'd2, 16'd3, 2'd0, 16'h0040, 16'h0);
      #1;
      chk("mulfl_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("mulfl_add", {out_valid, out_result}, {1'b1, 16'd5});
      vc = 0;
      for (int k = 0; k < 20; k++) begin step(); vc += int'(out_valid); end
      chk("mulfl_no_late", vc, 0);

      drive(3'd7, 16'h0123, 16'h0045, 2'd0, 16'h0040, 16'h0010);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) step();
      #3 rst_n = 1'b0;
      #1;
      chk("mulrst_outs", {out_valid, out_result}, '0);
      @(negedge clk); rst_n = 1'b1; #1;
      vc = 0;
      for (int k = 0; k < 20; k++) begin step(); vc += int'(out_valid); end
      chk("mulrst_no_partial", vc, 0);
    end
`endif

    // Randomized traffic with backpressure against the reference model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_br     = 2'($urandom_range(0, 3));
      in_a      = 16'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? in_a : 16'($urandom);
      in_imm    = 16'($urandom);
      in_b_src  = 1'($urandom_range(0, 1));
      in_pc_inc = 16'($urandom);
      in_disp   = 16'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (sq.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          exp_t e;
          e = sq.pop_front();
          chk($sformatf("rnd%0d", c), {out_result, out_next_pc, out_redirect, out_err}, e);
        end
      end
      if (in_valid && in_ready)
        sq.push_back(model(in_op, in_a, in_b_src ? in_imm : in_b, in_pc_inc, in_disp, in_br));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && sq.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        exp_t e;
        e = sq.pop_front();
        chk("rnd_drain", {out_result, out_next_pc, out_redirect, out_err}, e);
      end
      step();
    end
    chk("rnd_queue_empty", sq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
